// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM state type and default memory depth for the load/store unit
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam int DEPTH_WORDS_DEF = 128;
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_t;
endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: little-endian lane extract/extend (merge_sel=0) or sub-word merge (merge_sel=1); ports word/wdata in, offset/size/uns select lane, y out
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic        merge_sel,
  output logic [31:0] y
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] ext, mrg;
  always_comb begin
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    ext = size == SZ_B ? {{24{b[7] & ~uns}}, b} : size == SZ_H ? {{16{h[15] & ~uns}}, h} : word;
    mrg = word;
    if (size == SZ_B) mrg[{offset, 3'b000} +: 8] = wdata[7:0];
    else if (size == SZ_H) mrg[{offset[1], 4'b0000} +: 16] = wdata[15:0];
    else mrg = wdata;
    y = merge_sel ? mrg : ext;
  end
endmodule

// File: rtl/lsu.sv
// lsu: byte-addressed load/store unit in front of a word-indexed memory; req_* in, resp_* out, mem_* drive the memory data port
module lsu
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen
);
  state_t st, st_n;
  logic [31:0] r_addr, r_wdata, merge_q, rdata_q, ext, mrg;
  logic [1:0]  r_size;
  logic        r_uns, r_err, acc_err;
  assign acc_err = req_size == 2'b11 || (req_size == SZ_H && req_addr[0]) ||
                   (req_size == SZ_W && req_addr[1:0] != 2'b00) ||
                   {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign req_ready  = st == IDLE;
  assign mem_wen    = st == WRITE;
  assign resp_valid = st == DONE;
  assign resp_err   = resp_valid & r_err;
  assign resp_rdata = rdata_q;
  assign mem_raddr  = {2'b00, r_addr[31:2]};
  assign mem_waddr  = {2'b00, r_addr[31:2]};
  assign mem_wdata  = r_size == SZ_W ? r_wdata : merge_q;
  lsu_lane u_ext (.word(mem_rdata), .wdata(r_wdata), .offset(r_addr[1:0]), .size(r_size),
                  .uns(r_uns), .merge_sel(1'b0), .y(ext));
  lsu_lane u_mrg (.word(mem_rdata), .wdata(r_wdata), .offset(r_addr[1:0]), .size(r_size),
                  .uns(r_uns), .merge_sel(1'b1), .y(mrg));
  always_comb begin
    st_n = st == IDLE   ? (!req_valid ? IDLE : acc_err ? DONE : !req_wen ? LOAD :
                           req_size == SZ_W ? WRITE : RMW_RD) :
           st == LOAD   ? DONE :
           st == RMW_RD ? WRITE :
           st == WRITE  ? DONE : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      st <= st_n;
      if (req_valid && req_ready) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_err   <= acc_err;
        rdata_q <= '0;
      end
      if (st == LOAD) rdata_q <= ext;
      if (st == RMW_RD) merge_q <= mrg;
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu with a behavioural word memory
module tb_lsu;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_wen = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0] req_size = '0;
  logic req_ready, resp_valid, resp_err, mem_wen;
  logic [31:0] resp_rdata, mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic [31:0] mem [0:127];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_raddr[6:0]];
  always @(posedge clk) if (mem_wen) mem[mem_waddr[6:0]] <= mem_wdata;
  lsu dut (.clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
           .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
           .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_raddr(mem_raddr),
           .mem_rdata(mem_rdata), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wen(mem_wen));
  // Called 1 time unit after an edge with the LSU idle; k counts edges since the request was first presented.
  task automatic xfer(input logic wen, input logic [31:0] addr, input logic [1:0] size, input logic uns,
                      input logic [31:0] wdata, output int k_resp, output int k_wen, output int n_wen,
                      output logic err, output logic [31:0] rdata, output logic [31:0] waddr, output logic [31:0] wdat);
    req_wen = wen; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata; req_valid = 1'b1;
    k_resp = -1; k_wen = -1; n_wen = 0; err = 1'bx; rdata = 'x; waddr = 'x; wdat = 'x;
    for (int k = 1; k <= 8 && k_resp < 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) req_valid = 1'b0;
      if (mem_wen) begin n_wen++; k_wen = k; waddr = mem_waddr; wdat = mem_wdata; end
      if (resp_valid) begin k_resp = k; err = resp_err; rdata = resp_rdata; end
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    tests++; if (resp_valid !== 1'b0 || mem_wen !== 1'b0) begin fails++; $display("FAIL reset_strobes got valid=%b wen=%b exp 0 0", resp_valid, mem_wen); end
    tests++; if ({resp_rdata, mem_raddr, mem_waddr, mem_wdata} !== 128'd0) begin fails++; $display("FAIL reset_data got %h %h %h %h exp all 0", resp_rdata, mem_raddr, mem_waddr, mem_wdata); end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_word_store_load();
    int kr, kw, nw; logic e; logic [31:0] rd, wa, wd;
    mem[4] = 32'h0;
    xfer(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, kr, kw, nw, e, rd, wa, wd);
    tests++; if (kw !== 1 || nw !== 1) begin fails++; $display("FAIL wstore_wen got k=%0d n=%0d exp k=1 n=1", kw, nw); end
    tests++; if (wa !== 32'd4 || wd !== 32'hDEADBEEF) begin fails++; $display("FAIL wstore_addr_data got %h %h exp 4 deadbeef", wa, wd); end
    tests++; if (kr !== 2 || e !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL wstore_resp got k=%0d err=%b rd=%h exp k=2 err=0 rd=0", kr, e, rd); end
    tests++; if (mem[4] !== 32'hDEADBEEF) begin fails++; $display("FAIL wstore_mem got %h exp deadbeef", mem[4]); end
    xfer(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, kr, kw, nw, e, rd, wa, wd);
    tests++; if (kr !== 2 || e !== 1'b0 || rd !== 32'hDEADBEEF || nw !== 0) begin fails++; $display("FAIL wload got k=%0d err=%b rd=%h nwen=%0d exp k=2 err=0 rd=deadbeef nwen=0", kr, e, rd, nw); end
  endtask
  task automatic test_subword_rmw();
    int kr, kw, nw; logic e; logic [31:0] rd, wa, wd;
    mem[4] = 32'h11223344;
    xfer(1'b1, 32'h12, 2'b00, 1'b0, 32'h123456AA, kr, kw, nw, e, rd, wa, wd);
    tests++; if (wd !== 32'h11AA3344 || wa !== 32'd4 || kw !== 2 || nw !== 1) begin fails++; $display("FAIL byte_rmw_write got wd=%h wa=%h k=%0d n=%0d exp 11aa3344 4 2 1", wd, wa, kw, nw); end
    tests++; if (kr !== 3 || e !== 1'b0) begin fails++; $display("FAIL byte_rmw_resp got k=%0d err=%b exp k=3 err=0", kr, e); end
    xfer(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, kr, kw, nw, e, rd, wa, wd);
    tests++; if (rd !== 32'h11AA3344) begin fails++; $display("FAIL byte_rmw_readback got %h exp 11aa3344", rd); end
    mem[5] = 32'h8001F00F;
    xfer(1'b1, 32'h16, 2'b01, 1'b0, 32'h0000BEEF, kr, kw, nw, e, rd, wa, wd);
    tests++; if (mem[5] !== 32'hBEEFF00F || kr !== 3) begin fails++; $display("FAIL half_rmw got mem=%h k=%0d exp beeff00f k=3", mem[5], kr); end
  endtask
  task automatic test_extension();
    logic [31:0] addr [6] = '{32'h12, 32'h12, 32'h12, 32'h13, 32'h16, 32'h16};
    logic [1:0] size [6] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01};
    logic uns [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp_rd [6] = '{32'hFFFFFFAA, 32'h000000AA, 32'h000011AA, 32'h00000011, 32'hFFFF8001, 32'h00008001};
    int kr, kw, nw; logic e; logic [31:0] rd, wa, wd;
    mem[4] = 32'h11AA3344; mem[5] = 32'h8001F00F;
    for (int i = 0; i < 6; i++) begin
      xfer(1'b0, addr[i], size[i], uns[i], 32'h0, kr, kw, nw, e, rd, wa, wd);
      tests++; if (rd !== exp_rd[i] || kr !== 2 || e !== 1'b0) begin fails++; $display("FAIL extend_%0d got rd=%h k=%0d err=%b exp rd=%h k=2 err=0", i, rd, kr, e, exp_rd[i]); end
    end
  endtask
  task automatic test_errors();
    logic [31:0] addr [5] = '{32'h13, 32'h06, 32'h10, 32'h200, 32'h1FC};
    logic [1:0] size [5] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b10};
    logic exp_e [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int kr, kw, nw; logic e; logic [31:0] rd, wa, wd;
    for (int i = 0; i < 5; i++) begin
      xfer(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, kr, kw, nw, e, rd, wa, wd);
      xfer(1'b1, addr[i], size[i], 1'b0, 32'hCAFEF00D, kr, kw, nw, e, rd, wa, wd);
      if (exp_e[i]) begin
        tests++; if (e !== 1'b1 || kr !== 1 || nw !== 0 || rd !== 32'h0) begin fails++; $display("FAIL error_%0d got err=%b k=%0d nwen=%0d rd=%h exp err=1 k=1 nwen=0 rd=0", i, e, kr, nw, rd); end
      end else begin
        tests++; if (e !== 1'b0 || kr !== 2 || nw !== 1 || mem[127] !== 32'hCAFEF00D) begin fails++; $display("FAIL last_word got err=%b k=%0d nwen=%0d mem=%h exp err=0 k=2 nwen=1 mem=cafef00d", e, kr, nw, mem[127]); end
      end
    end
  endtask
  task automatic test_reset_mid_write();
    int seen = 0, k_wen = -1;
    mem[6] = 32'h55667788;
    req_wen = 1'b1; req_addr = 32'h18; req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'h99; req_valid = 1'b1;
    for (int k = 1; k <= 6 && k_wen < 0; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (resp_valid) seen++;
      if (mem_wen) k_wen = k;
    end
    tests++; if (k_wen !== 2) begin fails++; $display("FAIL rst_mid_reach_write got k=%0d exp 2", k_wen); end
    rst = 1'b1; #1;
    tests++; if (mem_wen !== 1'b0) begin fails++; $display("FAIL rst_mid_wen_drop got %b exp 0", mem_wen); end
    for (int k = 0; k < 2; k++) begin @(posedge clk); #1; if (resp_valid) seen++; end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin if (resp_valid) seen++; @(posedge clk); #1; end
    tests++; if (mem[6] !== 32'h55667788) begin fails++; $display("FAIL rst_mid_mem got %h exp 55667788", mem[6]); end
    tests++; if (seen !== 0) begin fails++; $display("FAIL rst_mid_resp got %0d responses exp 0", seen); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready got %b exp 1", req_ready); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] addr [3] = '{32'h10, 32'h11, 32'h13};
    logic [1:0] size [3] = '{2'b10, 2'b00, 2'b01};
    logic [31:0] exp_rd [3] = '{32'h11AA3344, 32'h00000033, 32'h0};
    logic exp_e [3] = '{1'b0, 1'b0, 1'b1};
    int exp_acc [3] = '{0, 3, 6};
    int exp_rc [3] = '{2, 5, 7};
    logic [31:0] rd [3]; logic e [3]; int rc [3], acc [3];
    int i = 0, nr = 0;
    mem[4] = 32'h11AA3344;
    req_wen = 1'b0; req_unsigned = 1'b1; req_wdata = 32'h0;
    req_addr = addr[0]; req_size = size[0]; req_valid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (resp_valid) begin
        if (nr < 3) begin rd[nr] = resp_rdata; e[nr] = resp_err; rc[nr] = c; end
        nr++;
      end
      if (req_ready && req_valid && i < 3) begin acc[i] = c; i++; end
      @(posedge clk); #1;
      if (i < 3) begin req_addr = addr[i]; req_size = size[i]; end
      else req_valid = 1'b0;
    end
    tests++; if (nr !== 3) begin fails++; $display("FAIL b2b_count got %0d responses exp 3", nr); end
    for (int j = 0; j < 3 && j < nr; j++) begin
      tests++; if (acc[j] !== exp_acc[j] || rc[j] !== exp_rc[j]) begin fails++; $display("FAIL b2b_timing_%0d got acc=%0d resp=%0d exp acc=%0d resp=%0d", j, acc[j], rc[j], exp_acc[j], exp_rc[j]); end
      tests++; if (rd[j] !== exp_rd[j] || e[j] !== exp_e[j]) begin fails++; $display("FAIL b2b_resp_%0d got rd=%h err=%b exp rd=%h err=%b", j, rd[j], e[j], exp_rd[j], exp_e[j]); end
    end
  endtask
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    test_reset();
    test_word_store_load();
    test_subword_rmw();
    test_extension();
    test_errors();
    test_reset_mid_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly upstream of the data port of the NPC's word-indexed memory. It converts byte-addressed load/store requests from the execute stage into word-index memory accesses. Sub-word stores use a read-modify-write, because the memory writes whole words only. Loaded bytes and halfwords are extracted and sign- or zero-extended, and misaligned or out-of-range requests are reported as errors.

## Interface
Parameters:
- `DEPTH_WORDS`, 128: number of 32-bit words in the attached memory; used for the range check.

Ports:
- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  LSU can accept a request; high only in IDLE.
- `req_wen`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_size`  in  2  size: 00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned`  in  1  zero-extend loads when 1, sign-extend when 0.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `resp_err`  out  1  qualified by `resp_valid`.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `mem_raddr`  out  32  word index, zero-extended to 32 bits.
- `mem_rdata`  in  32  combinational read data for `mem_raddr`.
- `mem_waddr`  out  32  word index, zero-extended to 32 bits.
- `mem_wdata`  out  32  full word to write.
- `mem_wen`  out  1  write strobe; the memory commits on the next rising edge.

## Operation
- Request capture: on `req_valid && req_ready`, latch wen, addr, size, unsigned and wdata. Word index = `addr[31:2]`; byte offset = `addr[1:0]`.
- Error detection at accept time, in this priority order:
  - size = 11;
  - half with `addr[0]` = 1;
  - word with `addr[1:0]` != 0;
  - word index >= `DEPTH_WORDS`.
  - An errored request never asserts `mem_wen`.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, DONE.
- Transitions:
  - IDLE -> DONE if the request errors.
  - IDLE -> LOAD for a load.
  - IDLE -> WRITE for a word store.
  - IDLE -> RMW_RD for a byte or half store.
  - LOAD -> DONE.
  - RMW_RD -> WRITE.
  - WRITE -> DONE.
  - DONE -> IDLE.
- LOAD: drive `mem_raddr` with the word index.
  - Byte: take lane `offset*8`.
  - Half: take lane `offset[1]*16`.
  - Extend the result to 32 bits, then register it into `resp_rdata`.
- RMW_RD: register `mem_rdata` into the merge register. Replace the addressed byte lane with `wdata[7:0]`, or the addressed half lane with `wdata[15:0]`. All other lanes are kept.
- WRITE: `mem_wen` = 1. `mem_waddr` = word index. `mem_wdata` = merged word for sub-word stores, or `wdata` for word stores.
- DONE: `resp_valid` = 1 and `resp_err` = latched error flag. Back to IDLE next cycle.
- Byte order: little-endian lane ordering throughout.

## Timing
- Request accepted at edge N. `resp_valid` is high during the cycle that starts at:
  - error: edge N+1;
  - load: edge N+2;
  - word store: edge N+2, with memory updated at edge N+2;
  - sub-word store: edge N+3.
- Next request acceptable at the earliest one cycle after DONE.
- `req_ready`, `mem_wen` and `resp_valid` are decoded combinationally from the state register. `mem_wen` is high for exactly one cycle per store.
- Address outputs are driven from latched registers, so they are stable for the whole LOAD, RMW_RD and WRITE cycles.
- Reset values:
  - state = IDLE, so `req_ready` = 1;
  - `resp_valid`, `resp_err`, `mem_wen` = 0;
  - `resp_rdata`, `mem_raddr`, `mem_waddr`, `mem_wdata` = 0;
  - merge register = 0.
- Reset mid-operation: `mem_wen` drops immediately, without waiting for a clock edge. A pending store is dropped with no partial write, and no response is issued.
- `req_valid` while not ready is ignored; the request is not queued.

## Structure
- Shared package `lsu_pkg`:
  - size encodings `SZ_B`, `SZ_H`, `SZ_W`;
  - FSM state enum;
  - `DEPTH_WORDS` default.
- Sub-module `lsu_lane` (combinational):
  - `extract(word, offset, size, unsigned)` gives the extended load value;
  - `merge(word, wdata, offset, size)` gives the RMW word.
  - Instantiated once for extract and once for merge.
- Sequential logic (FSM, request latches, merge register, response register) lives in `lsu`.

## Test plan
- Word store then load: store 0xDEADBEEF at byte address 0x10.
  - `mem_wen` is pulsed at N+1 with `mem_waddr` = 4.
  - A load of 0x10 returns 0xDEADBEEF with `resp_valid` at N+2.
- Byte RMW: word 4 = 0x11223344; store byte 0xAA at address 0x12.
  - `mem_wdata` = 0x11AA3344.
  - `resp_valid` at N+3; word 4 reads back 0x11AA3344.
- Extension: word 4 = 0x11AA3344.
  - Load byte at 0x12 signed gives 0xFFFFFFAA; unsigned gives 0x000000AA.
  - Load half at 0x12 signed gives 0x000011AA.
- Errors, each with `resp_err` = 1 at N+1, `mem_wen` never asserted and `resp_rdata` = 0:
  - half at 0x13;
  - word at 0x06;
  - size = 11;
  - word at 0x200 (index 128).
- Reset during WRITE of a sub-word store:
  - `mem_wen` falls on `rst` assertion before the next edge;
  - the target word is unchanged;
  - no `resp_valid` is issued;
  - `req_ready` = 1 after reset.
- Back-to-back: `req_valid` held high for 3 requests.
  - Each is accepted only in IDLE.
  - `req_valid` in non-IDLE cycles is ignored.
  - Responses arrive in order, one per request.
